ag_tcu_uop_seq: RTL and testbench

Micro-op sequencer directly upstream of the AG-TCU execute datapath. It accepts one WMMA instruction per handshake and expands it into `AG_TCU_UOPS` micro-ops. Each micro-op carries its (step_m, step_n, step_k) coordinates and its A/B/C register indices. It sits between dispatch and the TCU lanes, and is the only producer of `step_m`/`step_n`/`step_k` for the integer TCU path.

---
 rtl/VX_ag_tcu_pkg.sv | 51 +++++
 rtl/ag_tcu_uop_seq.sv | 177 +++++++++++++++++
 tb/tb_ag_tcu_uop_seq.sv | 297 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/VX_ag_tcu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : VX_ag_tcu_pkg
// Brief    : Shared constants and types for the AG-TCU integer path
//            (step geometry, register bases, format IDs, micro-op record).
// Revision : 1.0 - initial release
// ============================================================================
package VX_ag_tcu_pkg;

    // Tile step geometry of one WMMA instruction
    localparam int AG_TCU_M_STEPS  = 4;
    localparam int AG_TCU_N_STEPS  = 4;
    localparam int AG_TCU_K_STEPS  = 4;
    localparam int AG_TCU_UOPS     = AG_TCU_M_STEPS * AG_TCU_N_STEPS * AG_TCU_K_STEPS;
    localparam int AG_TCU_UOP_BITS = $clog2(AG_TCU_UOPS);

    // Step coordinate widths
    localparam int AG_TCU_M_BITS = $clog2(AG_TCU_M_STEPS);
    localparam int AG_TCU_N_BITS = $clog2(AG_TCU_N_STEPS);
    localparam int AG_TCU_K_BITS = $clog2(AG_TCU_K_STEPS);

    // Register file layout of the A, B and C/D fragments
    localparam int AG_TCU_REG_BITS     = 6;
    localparam int AG_TCU_RA           = 0;
    localparam int AG_TCU_RB           = 10;
    localparam int AG_TCU_RC           = 24;
    localparam int AG_TCU_A_SUB_BLOCKS = 1;
    localparam int AG_TCU_B_SUB_BLOCKS = 2;

    // Format identifiers
    localparam logic [3:0] AG_TCU_I32_ID = 4'd8;
    localparam logic [3:0] AG_TCU_I8_ID  = 4'd9;
    localparam logic [3:0] AG_TCU_U8_ID  = 4'd10;
    localparam logic [3:0] AG_TCU_I4_ID  = 4'd11;
    localparam logic [3:0] AG_TCU_U4_ID  = 4'd12;

    // One micro-op as seen by the TCU lanes (default geometry)
    typedef struct packed {
        logic [AG_TCU_M_BITS-1:0]   step_m;
        logic [AG_TCU_N_BITS-1:0]   step_n;
        logic [AG_TCU_K_BITS-1:0]   step_k;
        logic [AG_TCU_REG_BITS-1:0] rs1;
        logic [AG_TCU_REG_BITS-1:0] rs2;
        logic [AG_TCU_REG_BITS-1:0] rs3;
        logic                       first_k;
        logic                       last_k;
        logic                       eop;
    } ag_tcu_uop_t;

endpackage
`default_nettype wire

// File: rtl/ag_tcu_uop_seq.sv
`default_nettype none
// ============================================================================
// Module   : ag_tcu_uop_seq
// Brief    : Expands one WMMA instruction into M*N*K micro-ops in k/n/m order,
//            attaching step coordinates and A/B/C register indices.
// Revision : 1.0 - initial release
// ============================================================================
module ag_tcu_uop_seq
    import VX_ag_tcu_pkg::*;
#(
    parameter int M_STEPS  = AG_TCU_M_STEPS,
    parameter int N_STEPS  = AG_TCU_N_STEPS,
    parameter int K_STEPS  = AG_TCU_K_STEPS,
    parameter int REG_BITS = 6,
    parameter int TAG_BITS = 44
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [3:0]                 in_fmt_s,
    input  logic [3:0]                 in_fmt_d,
    input  logic [TAG_BITS-1:0]        in_tag,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [$clog2(M_STEPS)-1:0] out_step_m,
    output logic [$clog2(N_STEPS)-1:0] out_step_n,
    output logic [$clog2(K_STEPS)-1:0] out_step_k,
    output logic [REG_BITS-1:0]        out_rs1,
    output logic [REG_BITS-1:0]        out_rs2,
    output logic [REG_BITS-1:0]        out_rs3,
    output logic [3:0]                 out_fmt_s,
    output logic [3:0]                 out_fmt_d,
    output logic [TAG_BITS-1:0]        out_tag,
    output logic                       out_first_k,
    output logic                       out_last_k,
    output logic                       out_eop
);

    localparam int M_BITS   = $clog2(M_STEPS);
    localparam int N_BITS   = $clog2(N_STEPS);
    localparam int K_BITS   = $clog2(K_STEPS);
    localparam int UOPS     = M_STEPS * N_STEPS * K_STEPS;
    localparam int UOP_BITS = $clog2(UOPS);
    localparam int RS3_MAX  = AG_TCU_RC + M_STEPS * N_STEPS - 1;

    localparam logic [UOP_BITS-1:0] C_LAST_UOP = UOP_BITS'(UOPS - 1);
    localparam logic [REG_BITS-1:0] C_RA       = REG_BITS'(AG_TCU_RA);
    localparam logic [REG_BITS-1:0] C_RB       = REG_BITS'(AG_TCU_RB);
    localparam logic [REG_BITS-1:0] C_RC       = REG_BITS'(AG_TCU_RC);
    localparam logic [REG_BITS-1:0] C_N_STEPS  = REG_BITS'(N_STEPS);
    localparam logic [REG_BITS-1:0] C_K_STEPS  = REG_BITS'(K_STEPS);
    localparam logic [REG_BITS-1:0] C_A_SUB    = REG_BITS'(AG_TCU_A_SUB_BLOCKS);
    localparam logic [REG_BITS-1:0] C_B_SUB    = REG_BITS'(AG_TCU_B_SUB_BLOCKS);

    // The flat counter is sliced into {m, n, k}, so every step count must be a
    // power of two of at least 2; the C/D range must also fit the index width.
    if ((M_STEPS < 2) || ((M_STEPS & (M_STEPS - 1)) != 0) ||
        (N_STEPS < 2) || ((N_STEPS & (N_STEPS - 1)) != 0) ||
        (K_STEPS < 2) || ((K_STEPS & (K_STEPS - 1)) != 0)) begin : g_chk_pow2
        $error("ag_tcu_uop_seq: step counts must be powers of two >= 2");
    end

    if (RS3_MAX >= (1 << REG_BITS)) begin : g_chk_rs3
        $error("ag_tcu_uop_seq: C/D register range exceeds REG_BITS");
    end

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_ISSUE = 1'b1
    } state_t;

    state_t                r_state;
    logic [UOP_BITS-1:0]   r_cnt;
    logic [3:0]            r_fmt_s;
    logic [3:0]            r_fmt_d;
    logic [TAG_BITS-1:0]   r_tag;

    logic                  w_issue;
    logic                  w_eop;
    logic                  w_fire;
    logic                  w_eop_fire;
    logic [M_BITS-1:0]     w_m;
    logic [N_BITS-1:0]     w_n;
    logic [K_BITS-1:0]     w_k;
    logic [REG_BITS-1:0]   w_a_lin;
    logic [REG_BITS-1:0]   w_b_lin;
    logic [REG_BITS-1:0]   w_rs1;
    logic [REG_BITS-1:0]   w_rs2;
    logic [REG_BITS-1:0]   w_rs3;

    assign w_issue    = (r_state == ST_ISSUE);
    assign w_m        = r_cnt[K_BITS + N_BITS +: M_BITS];
    assign w_n        = r_cnt[K_BITS +: N_BITS];
    assign w_k        = r_cnt[0 +: K_BITS];
    assign w_eop      = (r_cnt == C_LAST_UOP);
    assign w_fire     = w_issue & out_ready;
    assign w_eop_fire = w_fire & w_eop;

    // Register indices are pure functions of the current step coordinates
    assign w_a_lin = REG_BITS'(w_m) * C_K_STEPS + REG_BITS'(w_k);
    assign w_b_lin = REG_BITS'(w_k) * C_N_STEPS + REG_BITS'(w_n);
    assign w_rs1   = C_RA + w_a_lin / C_A_SUB;
    assign w_rs2   = C_RB + w_b_lin / C_B_SUB;
    assign w_rs3   = C_RC + REG_BITS'(w_m) * C_N_STEPS + REG_BITS'(w_n);

    // A new instruction can be taken when idle or on the final micro-op fire
    assign in_ready = ~w_issue | w_eop_fire;

    // Per-micro-op fields read as zero while idle so the bus is quiet
    assign out_valid   = w_issue;
    assign out_step_m  = w_issue ? w_m   : '0;
    assign out_step_n  = w_issue ? w_n   : '0;
    assign out_step_k  = w_issue ? w_k   : '0;
    assign out_rs1     = w_issue ? w_rs1 : '0;
    assign out_rs2     = w_issue ? w_rs2 : '0;
    assign out_rs3     = w_issue ? w_rs3 : '0;
    assign out_first_k = w_issue & (w_k == '0);
    assign out_last_k  = w_issue & (w_k == K_BITS'(K_STEPS - 1));
    assign out_eop     = w_issue & w_eop;
    assign out_fmt_s   = r_fmt_s;
    assign out_fmt_d   = r_fmt_d;
    assign out_tag     = r_tag;

    // Sequencer state, step counter and latched instruction fields
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_fmt_s <= '0;
            r_fmt_d <= '0;
            r_tag   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_state <= ST_ISSUE;
                        r_cnt   <= '0;
                        r_fmt_s <= in_fmt_s;
                        r_fmt_d <= in_fmt_d;
                        r_tag   <= in_tag;
                    end
                end
                ST_ISSUE: begin
                    if (w_fire) begin
                        if (w_eop) begin
                            r_cnt <= '0;
                            // Back-to-back load keeps issuing with no bubble
                            if (in_valid) begin
                                r_fmt_s <= in_fmt_s;
                                r_fmt_d <= in_fmt_d;
                                r_tag   <= in_tag;
                            end else begin
                                r_state <= ST_IDLE;
                            end
                        end else begin
                            r_cnt <= r_cnt + UOP_BITS'(1);
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

`ifndef SYNTHESIS
    // Unsupported source formats are still sequenced but flagged in simulation
    always_ff @(posedge clk) begin
        if (reset && in_valid && in_ready) begin
            assert ((in_fmt_s >= AG_TCU_I8_ID) && (in_fmt_s <= AG_TCU_U4_ID))
                else $error("ag_tcu_uop_seq: unsupported fmt_s %0d", in_fmt_s);
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_ag_tcu_uop_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_ag_tcu_uop_seq
// Brief    : Scoreboard bench for ag_tcu_uop_seq: driver pushes expected
//            micro-ops, monitor pops and compares on every output fire.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ag_tcu_uop_seq;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_fmt_s;
    logic [3:0]  in_fmt_d;
    logic [43:0] in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [1:0]  out_step_m;
    logic [1:0]  out_step_n;
    logic [1:0]  out_step_k;
    logic [5:0]  out_rs1;
    logic [5:0]  out_rs2;
    logic [5:0]  out_rs3;
    logic [3:0]  out_fmt_s;
    logic [3:0]  out_fmt_d;
    logic [43:0] out_tag;
    logic        out_first_k;
    logic        out_last_k;
    logic        out_eop;

    ag_tcu_uop_seq dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_fmt_s    (in_fmt_s),
        .in_fmt_d    (in_fmt_d),
        .in_tag      (in_tag),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_step_m  (out_step_m),
        .out_step_n  (out_step_n),
        .out_step_k  (out_step_k),
        .out_rs1     (out_rs1),
        .out_rs2     (out_rs2),
        .out_rs3     (out_rs3),
        .out_fmt_s   (out_fmt_s),
        .out_fmt_d   (out_fmt_d),
        .out_tag     (out_tag),
        .out_first_k (out_first_k),
        .out_last_k  (out_last_k),
        .out_eop     (out_eop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          idx;
        int          m;
        int          n;
        int          k;
        int          rs1;
        int          rs2;
        int          rs3;
        bit          fk;
        bit          lk;
        bit          eop;
        logic [43:0] tag;
    } exp_t;

    exp_t q[$];
    int   checks    = 0;
    int   errors    = 0;
    int   fk_cnt    = 0;
    int   lk_cnt    = 0;
    bit   chk_gap   = 0;

    task automatic check(input string name, input logic [79:0] act, input logic [79:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Expected micro-op stream for one instruction, k innermost then n then m
    task automatic push_inst(input logic [43:0] tag);
        exp_t e;
        for (int i = 0; i < 64; i++) begin
            e.idx = i;
            e.k   = i % 4;
            e.n   = (i / 4) % 4;
            e.m   = i / 16;
            e.rs1 = 0 + (e.m * 4 + e.k) / 1;
            e.rs2 = 10 + (e.k * 4 + e.n) / 2;
            e.rs3 = 24 + e.m * 4 + e.n;
            e.fk  = (e.k == 0);
            e.lk  = (e.k == 3);
            e.eop = (i == 63);
            e.tag = tag;
            q.push_back(e);
        end
    endtask

    function automatic logic [79:0] snap();
        return {out_valid, out_step_m, out_step_n, out_step_k, out_rs1, out_rs2,
                out_rs3, out_fmt_s, out_fmt_d, out_tag, out_first_k, out_last_k, out_eop};
    endfunction

    // Monitor: compares every fire against the scoreboard head, checks stalls
    initial begin
        exp_t        e;
        bit          fired;
        bit          prev_stall = 0;
        logic [79:0] snap_prev  = '0;
        int          cyc        = 0;
        int          last_fire  = -1;
        forever begin
            @(negedge clk);
            cyc++;
            fired = reset && out_valid && out_ready;
            if (reset && prev_stall) check("stall_stable", snap(), snap_prev);
            prev_stall = reset && out_valid && !out_ready;
            snap_prev  = snap();
            if (fired) begin
                if (q.size() == 0) begin
                    check("unexpected_uop", {79'd0, out_valid}, 80'd0);
                end else begin
                    e = q[0];
                    check("step_m",  out_step_m,  e.m);
                    check("step_n",  out_step_n,  e.n);
                    check("step_k",  out_step_k,  e.k);
                    check("rs1",     out_rs1,     e.rs1);
                    check("rs2",     out_rs2,     e.rs2);
                    check("rs3",     out_rs3,     e.rs3);
                    check("first_k", out_first_k, e.fk);
                    check("last_k",  out_last_k,  e.lk);
                    check("eop",     out_eop,     e.eop);
                    check("tag",     out_tag,     e.tag);
                    check("fmt_s",   out_fmt_s,   4'd9);
                    check("fmt_d",   out_fmt_d,   4'd8);
                    if (e.idx == 0)
                        check("first_regs", {out_rs1, out_rs2, out_rs3}, {6'd0, 6'd10, 6'd24});
                    if (e.idx == 63)
                        check("last_regs", {out_rs1, out_rs2, out_rs3}, {6'd15, 6'd17, 6'd39});
                end
                if (out_first_k) fk_cnt++;
                if (out_last_k)  lk_cnt++;
                if (chk_gap) begin
                    if (last_fire >= 0) check("fire_gap", cyc - last_fire, 1);
                    last_fire = cyc;
                end
            end
            if (!chk_gap) last_fire = -1;
            @(posedge clk);
            if (fired && q.size() > 0) void'(q.pop_front());
        end
    end

    // Present one instruction and hold it until accepted; in_ready is checked
    // against the scoreboard position every cycle while waiting.
    task automatic issue(input logic [43:0] tag, input bit rnd);
        int c   = 0;
        bit acc = 0;
        bit exp_rdy;
        in_valid = 1'b1;
        in_tag   = tag;
        in_fmt_s = 4'd9;
        in_fmt_d = 4'd8;
        while (!acc && c < 400) begin
            @(negedge clk);
            exp_rdy = (q.size() == 0) ? 1'b1 : (q[0].idx == 63 && out_ready);
            check("in_ready_issue", in_ready, exp_rdy);
            acc = in_ready;
            @(posedge clk);
            #1;
            if (acc) begin
                in_valid = 1'b0;
                in_tag   = '0;
                push_inst(tag);
            end
            out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            c++;
        end
        if (!acc) begin
            check("issue_timeout", {79'd0, in_ready}, 80'd1);
            in_valid = 1'b0;
        end
    endtask

    // Run until the scoreboard is empty
    task automatic drain(input bit rnd);
        int c = 0;
        while (q.size() > 0 && c < 1000) begin
            @(negedge clk);
            if (q.size() > 0)
                check("in_ready_drain", in_ready, (q[0].idx == 63 && out_ready));
            @(posedge clk);
            #1;
            out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            c++;
        end
        if (q.size() > 0) begin
            check("drain_timeout", q.size(), 0);
            q.delete();
        end
        out_ready = 1'b1;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit hit;
        reset     = 1'b0;
        in_valid  = 1'b0;
        in_tag    = '0;
        in_fmt_s  = 4'd9;
        in_fmt_d  = 4'd8;
        out_ready = 1'b1;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_in_ready",  in_ready,  1'b1);
        check("rst_rs",        {out_rs1, out_rs2, out_rs3}, 18'd0);
        check("rst_flags",     {out_first_k, out_last_k, out_eop}, 3'd0);
        check("rst_tag",       out_tag, 44'd0);
        @(posedge clk);
        #1 reset = 1'b1;

        // Single instruction, full throughput, one-cycle latency
        fk_cnt  = 0;
        lk_cnt  = 0;
        chk_gap = 1'b1;
        issue(44'h0A0A_1234_567, 1'b0);
        @(negedge clk);
        check("latency_valid", out_valid, 1'b1);
        drain(1'b0);
        chk_gap = 1'b0;
        check("first_k_count", fk_cnt, 16);
        check("last_k_count",  lk_cnt, 16);

        // Random backpressure
        issue(44'h0B0B_0000_0B1, 1'b1);
        drain(1'b1);

        // Back-to-back instructions with no bubble
        fk_cnt  = 0;
        lk_cnt  = 0;
        chk_gap = 1'b1;
        issue(44'h0C0C_0000_0C1, 1'b0);
        issue(44'h0D0D_0000_0D2, 1'b0);
        drain(1'b0);
        chk_gap = 1'b0;
        check("b2b_first_k_count", fk_cnt, 32);
        check("b2b_last_k_count",  lk_cnt, 32);

        // Reset at the 20th fire, then restart
        issue(44'h0E0E_0000_0E1, 1'b0);
        hit = 1'b0;
        for (int c = 0; c < 100 && !hit; c++) begin
            @(negedge clk);
            hit = out_valid && out_ready && q.size() > 0 && q[0].idx == 19;
            @(posedge clk);
            #1;
        end
        check("reset_point_seen", {79'd0, hit}, 80'd1);
        reset     = 1'b0;
        out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("midrst_out_valid", out_valid, 1'b0);
        check("midrst_in_ready",  in_ready,  1'b1);
        check("midrst_steps",     {out_step_m, out_step_n, out_step_k}, 6'd0);
        check("midrst_eop",       out_eop, 1'b0);
        @(posedge clk);
        #1;
        q.delete();
        reset     = 1'b1;
        out_ready = 1'b1;
        issue(44'h0F0F_0000_0F1, 1'b0);
        drain(1'b0);

        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
